// File: rtl/matrix_pkg.sv
// Shared types, opcodes and element helpers for the 4x4 matrix execution core.
package matrix_pkg;

    localparam int unsigned ELEM_W = 16;
    localparam int unsigned DIM    = 4;
    localparam int unsigned AW     = 4;
    localparam int unsigned MAT_W  = DIM * DIM * ELEM_W;
    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 8;

    typedef logic [MAT_W-1:0]  mat_t;
    typedef logic [ELEM_W-1:0] elem_t;

    localparam logic [OP_W-1:0] OP_NOP       = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD       = 8'h01;
    localparam logic [OP_W-1:0] OP_SUB       = 8'h02;
    localparam logic [OP_W-1:0] OP_SCALE     = 8'h03;
    localparam logic [OP_W-1:0] OP_TRANSPOSE = 8'h04;
    localparam logic [OP_W-1:0] OP_MATMUL    = 8'h05;
    localparam logic [OP_W-1:0] OP_STOP      = 8'hFF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ1  = 3'd2,
        ST_READ2  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] opcode;
        logic [7:0]      dest;
        logic [7:0]      src1;
        logic [7:0]      src2;
    } inst_t;

    // Element (r,c) lives at bit offset ELEM_W*(DIM*r+c).
    function automatic elem_t get_elem(input mat_t m, input int unsigned r, input int unsigned c);
        return m[ELEM_W*(DIM*r+c) +: ELEM_W];
    endfunction

    function automatic mat_t put_elem(input mat_t m, input int unsigned r, input int unsigned c,
                                      input elem_t v);
        mat_t res;
        res = m;
        res[ELEM_W*(DIM*r+c) +: ELEM_W] = v;
        return res;
    endfunction

endpackage

// File: rtl/matrix_alu.sv
// Combinational matrix ALU: element-wise add/sub/scale, transpose and matmul, all modulo 2^ELEM_W.
module matrix_alu
    import matrix_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  mat_t            a_i,
    input  mat_t            b_i,
    input  logic [7:0]      imm_i,
    output mat_t            r_c
);

    elem_t acc;

    always_comb begin
        r_c = '0;
        acc = '0;
        for (int unsigned r = 0; r < DIM; r++) begin
            for (int unsigned c = 0; c < DIM; c++) begin
                case (op_i)
                    OP_ADD:
                        r_c = put_elem(r_c, r, c, get_elem(a_i, r, c) + get_elem(b_i, r, c));
                    OP_SUB:
                        r_c = put_elem(r_c, r, c, get_elem(a_i, r, c) - get_elem(b_i, r, c));
                    OP_SCALE:
                        r_c = put_elem(r_c, r, c, elem_t'(get_elem(a_i, r, c) * ELEM_W'(imm_i)));
                    OP_TRANSPOSE:
                        r_c = put_elem(r_c, r, c, get_elem(a_i, c, r));
                    OP_MATMUL: begin
                        // Each product and the running sum wrap at ELEM_W bits.
                        acc = '0;
                        for (int unsigned k = 0; k < DIM; k++) begin
                            acc = acc + elem_t'(get_elem(a_i, r, k) * get_elem(b_i, k, c));
                        end
                        r_c = put_elem(r_c, r, c, acc);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/matrix_exec_core.sv
// Matrix engine execution core: PC, fetch/decode sequencer, instruction latch and ALU.
// The fetch strobe is issued on entry to FETCH; FETCH only advances once the store has seen it.
module matrix_exec_core
    import matrix_pkg::*;
(
    input  logic              Clock,
    input  logic              nReset,
    output logic [AW-1:0]     InstAddress,
    output logic              InstEnable,
    input  logic [INST_W-1:0] Data1,
    output logic [AW-1:0]     Address,
    output logic              Enable,
    output logic              ReadWrite,
    input  logic [MAT_W-1:0]  Data,
    output logic [MAT_W-1:0]  ALUData,
    output logic [OP_W-1:0]   Opcode,
    output logic              Status,
    output logic              Halted
);

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    inst_t          inst_q, inst_d;
    mat_t           a_q, a_d;
    mat_t           b_q, b_d;
    mat_t           alu_q, alu_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           inst_en_q, inst_en_d;
    logic           en_q, en_d;
    logic           rw_q, rw_d;
    logic           status_q, status_d;
    logic           halted_q, halted_d;

    mat_t           alu_b;
    mat_t           alu_r;
    inst_t          fetched;

    assign fetched = inst_t'(Data1);

    // B is taken straight from the RAM bus in EXEC so the result is ready for WRITE.
    assign alu_b = (state_q == ST_EXEC) ? Data : b_q;

    matrix_alu u_alu (
        .op_i  (inst_q.opcode),
        .a_i   (a_q),
        .b_i   (alu_b),
        .imm_i (inst_q.src2),
        .r_c   (alu_r)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            inst_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            addr_q    <= '0;
            inst_en_q <= 1'b0;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            status_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            addr_q    <= addr_d;
            inst_en_q <= inst_en_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            status_q  <= status_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        addr_d    = addr_q;
        inst_en_d = 1'b0;
        en_d      = 1'b0;
        rw_d      = 1'b0;
        status_d  = 1'b0;
        halted_d  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (inst_en_q) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                inst_d = fetched;
                case (fetched.opcode)
                    OP_STOP: state_d = ST_HALT;
                    OP_ADD, OP_SUB, OP_SCALE, OP_TRANSPOSE, OP_MATMUL: state_d = ST_READ1;
                    default: begin
                        pc_d    = pc_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_READ1: state_d = ST_READ2;
            ST_READ2: begin
                a_d     = Data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                b_d     = Data;
                alu_d   = alu_r;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                pc_d    = pc_q + AW'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Strobes are registered against the state being entered.
        case (state_d)
            ST_FETCH: inst_en_d = 1'b1;
            ST_READ1: begin
                en_d   = 1'b1;
                addr_d = AW'(inst_d.src1);
            end
            ST_READ2: begin
                en_d   = 1'b1;
                addr_d = AW'(inst_d.src2);
            end
            ST_WRITE: begin
                en_d     = 1'b1;
                rw_d     = 1'b1;
                status_d = 1'b1;
                addr_d   = AW'(inst_d.dest);
            end
            ST_HALT: halted_d = 1'b1;
            default: ;
        endcase
    end

    assign InstAddress = pc_q;
    assign InstEnable  = inst_en_q;
    assign Address     = addr_q;
    assign Enable      = en_q;
    assign ReadWrite   = rw_q;
    assign ALUData     = alu_q;
    assign Opcode      = inst_q.opcode;
    assign Status      = status_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_matrix_exec_core.sv
// Bench for matrix_exec_core: instruction store and data RAM models plus a
// program-level reference interpreter working on 4x4 element grids.
module tb_matrix_exec_core;

    logic         Clock;
    logic         nReset;
    logic [3:0]   InstAddress;
    logic         InstEnable;
    logic [31:0]  Data1;
    logic [3:0]   Address;
    logic         Enable;
    logic         ReadWrite;
    logic [255:0] Data;
    logic [255:0] ALUData;
    logic [7:0]   Opcode;
    logic         Status;
    logic         Halted;

    matrix_exec_core dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .InstAddress (InstAddress),
        .InstEnable  (InstEnable),
        .Data1       (Data1),
        .Address     (Address),
        .Enable      (Enable),
        .ReadWrite   (ReadWrite),
        .Data        (Data),
        .ALUData     (ALUData),
        .Opcode      (Opcode),
        .Status      (Status),
        .Halted      (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef logic [15:0] grid_t [4][4];

    logic [31:0]  imem [16];
    logic [255:0] dinit [16];
    logic [255:0] dmem [16];
    logic [255:0] exp_mem [16];
    logic         ld_all;
    int           status_cnt;
    int           strobe_cnt;
    int           overlap_cnt;
    int           checks;
    int           errors;

    // Synchronous stores: answer the cycle after a strobe; ld_all preloads the RAM.
    always @(posedge Clock) begin
        if (InstEnable) Data1 <= imem[InstAddress];
        if (ld_all) begin
            for (int i = 0; i < 16; i++) dmem[i] <= dinit[i];
        end else if (Enable) begin
            if (ReadWrite) dmem[Address] <= ALUData;
            else           Data <= dmem[Address];
        end
        if (Status) status_cnt <= status_cnt + 1;
        if (Enable) strobe_cnt <= strobe_cnt + 1;
        if (Enable && InstEnable) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        status_cnt  = 0;
        strobe_cnt  = 0;
        overlap_cnt = 0;
    end

    function automatic grid_t to_grid(input logic [255:0] m);
        grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = m[16*(4*r+c) +: 16];
        return g;
    endfunction

    function automatic logic [255:0] from_grid(input grid_t g);
        logic [255:0] m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[16*(4*r+c) +: 16] = g[r][c];
        return m;
    endfunction

    function automatic logic [255:0] fill(input logic [15:0] v);
        grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = v;
        return from_grid(g);
    endfunction

    // Element value = mul_r*r + mul_c*c, e.g. (4,1) gives 4r+c and (1,4) its transpose.
    function automatic logic [255:0] ramp(input int mul_r, input int mul_c);
        grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = 16'(mul_r * r + mul_c * c);
        return from_grid(g);
    endfunction

    function automatic logic [255:0] ref_op(input logic [7:0] op, input logic [255:0] a,
                                            input logic [255:0] b, input logic [7:0] imm);
        grid_t ga, gb, gr;
        int unsigned acc;
        ga = to_grid(a);
        gb = to_grid(b);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                case (op)
                    8'h01: acc = 32'(ga[r][c]) + 32'(gb[r][c]);
                    8'h02: acc = 32'(ga[r][c]) - 32'(gb[r][c]);
                    8'h03: acc = 32'(ga[r][c]) * 32'(imm);
                    8'h04: acc = 32'(ga[c][r]);
                    8'h05: for (int k = 0; k < 4; k++) acc = acc + 32'(ga[r][k]) * 32'(gb[k][c]);
                    default: acc = 0;
                endcase
                gr[r][c] = acc[15:0];
            end
        end
        return from_grid(gr);
    endfunction

    // Interpret the program in imem over dinit until STOP; results land in exp_mem.
    task automatic run_model(output int writes);
        logic [255:0] mm [16];
        logic [31:0]  w;
        int           pc;
        writes = 0;
        pc = 0;
        for (int i = 0; i < 16; i++) mm[i] = dinit[i];
        for (int s = 0; s < 64; s++) begin
            w = imem[pc];
            if (w[31:24] == 8'hFF) break;
            if (w[31:24] >= 8'h01 && w[31:24] <= 8'h05) begin
                mm[w[19:16]] = ref_op(w[31:24], mm[w[11:8]], mm[w[3:0]], w[7:0]);
                writes++;
            end
            pc = (pc + 1) % 16;
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = mm[i];
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic reset_and_load();
        nReset = 1'b0;
        ld_all = 1'b1;
        tick();
        ld_all = 1'b0;
        tick();
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!Halted && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 256'(Halted), 256'(1));
    endtask

    task automatic check_memory(input string tag, input int writes, input int status0);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), dmem[i], exp_mem[i]);
        chk({tag, "_status_pulses"}, 256'(status_cnt - status0), 256'(writes));
    endtask

    initial begin
        int           writes;
        int           s0;
        int           held_ok;
        logic [255:0] m;
        logic [7:0]   op;

        checks = 0;
        errors = 0;
        nReset = 1'b0;
        ld_all = 1'b0;
        for (int i = 0; i < 16; i++) begin
            imem[i]  = 32'h0;
            dinit[i] = 256'h0;
        end

        // Directed program covering ADD, SUB wrap, SCALE truncation, TRANSPOSE, MATMUL.
        imem[0] = 32'h01_02_00_01;
        imem[1] = 32'h02_05_03_04;
        imem[2] = 32'h03_07_06_02;
        imem[3] = 32'h04_09_08_00;
        imem[4] = 32'h05_0C_0A_0B;
        imem[5] = 32'h05_0F_0D_0E;
        imem[6] = 32'hFF_00_00_00;
        dinit[0]  = fill(16'd3);
        dinit[1]  = fill(16'd5);
        dinit[3]  = fill(16'd1);
        dinit[4]  = fill(16'd2);
        m = fill(16'd7);
        m[15:0] = 16'h8001;
        dinit[6]  = m;
        dinit[8]  = ramp(4, 1);
        m = 256'h0;
        for (int d = 0; d < 4; d++) m[16*(5*d) +: 16] = 16'd1;
        dinit[10] = m;
        dinit[11] = ramp(4, 1);
        dinit[13] = fill(16'd2);
        dinit[14] = fill(16'd2);
        run_model(writes);

        reset_and_load();
        chk("reset_inst_enable", 256'(InstEnable), 256'(0));
        chk("reset_strobes", {Enable, ReadWrite, Status, Halted}, 256'(0));
        chk("reset_opcode_addr", {Opcode, InstAddress, Address}, 256'(0));
        chk("reset_aludata", ALUData, 256'(0));

        s0 = status_cnt;
        nReset = 1'b1;
        repeat (5) tick();
        chk("t1_no_early_status", 256'(Status), 256'(0));
        tick();
        chk("t1_write_strobe", {Status, Enable, ReadWrite}, 256'(3'b111));
        chk("t1_write_addr", 256'(Address), 256'(2));
        chk("t1_write_data", ALUData, fill(16'd8));
        chk("t1_opcode", 256'(Opcode), 256'(8'h01));
        tick();
        chk("t1_status_one_cycle", 256'(Status), 256'(0));
        chk("t1_pc_next", 256'(InstAddress), 256'(1));
        chk("t1_fetch_strobe", {InstEnable, Enable}, 256'(2'b10));

        wait_halt("directed_halt", 80);
        chk("t1_add", dmem[2], fill(16'd8));
        chk("t2_sub_wrap", dmem[5], fill(16'hFFFF));
        m = dmem[7];
        chk("t3_scale_trunc", 256'(m[15:0]), 256'(16'h0002));
        chk("t4_transpose", dmem[9], ramp(1, 4));
        chk("t5_matmul_identity", dmem[12], ramp(4, 1));
        chk("t5_matmul_twos", dmem[15], fill(16'd16));
        check_memory("directed", writes, s0);

        // NOP, unknown opcode, STOP: no RAM traffic, then halt held until reset.
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;
        imem[1] = 32'h77_01_02_03;
        imem[2] = 32'hFF_00_00_00;
        reset_and_load();
        s0 = strobe_cnt;
        nReset = 1'b1;
        wait_halt("t6_halt", 12);
        held_ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!Halted || InstEnable || Enable) held_ok = 0;
        end
        chk("t6_halt_held_quiet", 256'(held_ok), 256'(1));
        chk("t6_no_ram_strobes", 256'(strobe_cnt - s0), 256'(0));
        chk("t6_opcode_stop", 256'(Opcode), 256'(8'hFF));
        chk("t6_pc_at_stop", 256'(InstAddress), 256'(2));
        @(posedge Clock);
        #3;
        nReset = 1'b0;
        #1;
        chk("t6_async_clear", {Halted, InstEnable, Opcode, InstAddress}, 256'(0));
        tick();
        nReset = 1'b1;
        tick();
        chk("t6_refetch", {InstEnable, InstAddress}, {251'(0), 1'b1, 4'h0});

        // Randomized programs: arbitrary upper field bits, dest aliasing, unknown opcodes.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                for (int w = 0; w < 8; w++) dinit[i][32*w +: 32] = $urandom;
                op = 8'($urandom_range(0, 6));
                if (op == 8'd6) op = 8'($urandom_range(6, 254));
                imem[i] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
            end
            imem[15] = 32'hFF_00_00_00;
            run_model(writes);
            reset_and_load();
            s0 = status_cnt;
            nReset = 1'b1;
            wait_halt($sformatf("rand%0d_halt", p), 120);
            check_memory($sformatf("rand%0d", p), writes, s0);
        end

        chk("no_fetch_during_ram_access", 256'(overlap_cnt), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_exec_core.md
Name: matrix_exec_core

Overview:
- Execution core of the 4x4 matrix engine: program counter, fetch/decode sequencer (exe), instruction latch (inst_register) and matrix ALU (alu).
- Fetches 32-bit instructions from an external instruction store.
- Reads two 256-bit matrix operands from the external data RAM, computes, and writes the result back to RAM.
- Sits between the instruction store and the data RAM; all sequencing decisions are made here.

Parameters:
- ELEM_W, 16, width of one matrix element (unsigned).
- DIM, 4, matrix dimension; matrix bus width = DIM*DIM*ELEM_W = 256.
- AW, 4, address width of both instruction store and data RAM (16 entries).

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- InstAddress  out  4  instruction store address (= PC).
- InstEnable  out  1  instruction read strobe.
- Data1  in  32  instruction word, valid the cycle after InstEnable.
- Address  out  4  data RAM address.
- Enable  out  1  data RAM strobe.
- ReadWrite  out  1  1 = write, 0 = read; qualified by Enable.
- Data  in  256  RAM read data, valid the cycle after a read strobe.
- ALUData  out  256  result / RAM write data.
- Opcode  out  8  opcode of the latched instruction.
- Status  out  1  one-cycle pulse on each result write.
- Halted  out  1  high after a STOP instruction.

Behaviour:
- Interface rule: one clock, Clock; reset is asynchronous and active-low, nReset.
- Reset state: FETCH, PC = 0, latched instruction = 0, operands = 0.
- All outputs are registered and reset to 0.
- Instruction format:
  - [31:24] opcode.
  - [23:16] dest; only the low AW bits are used.
  - [15:8] src1; only the low AW bits are used.
  - [7:0] src2; low AW bits form the address, all 8 bits form the immediate.
- Element (r,c) occupies bits [ELEM_W*(DIM*r+c) +: ELEM_W], r = row, c = column.
- States, one cycle each:
  - FETCH: InstEnable = 1, InstAddress = PC.
  - DECODE: latch Data1 and drive Opcode. STOP (8'hFF) goes to HALT. Unknown opcode: PC = PC+1, go to FETCH, no RAM access. Otherwise go to READ1.
  - READ1: Enable = 1, ReadWrite = 0, Address = src1.
  - READ2: capture A = Data; Enable = 1, ReadWrite = 0, Address = src2.
  - EXEC: capture B = Data; compute result into ALUData.
  - WRITE: Enable = 1, ReadWrite = 1, Address = dest, ALUData = result, Status = 1; PC = PC+1; go to FETCH.
  - HALT: Halted = 1; all strobes 0; held until reset.
- Latency: a valid ALU instruction takes exactly 6 cycles, FETCH through WRITE. NOP and unknown opcodes take 2.
- Opcodes; all arithmetic is unsigned, modulo 2^ELEM_W, with wrap and no saturation:
  - 8'h00 NOP.
  - 8'h01 ADD: R = A + B, element-wise.
  - 8'h02 SUB: R = A - B, element-wise, with wrap.
  - 8'h03 SCALE: R = A * imm8, where imm8 = src2 field; the product is truncated to ELEM_W bits.
  - 8'h04 TRANSPOSE: R(r,c) = A(c,r).
  - 8'h05 MATMUL: R(r,c) = sum over k of A(r,k)*B(k,c); each product and the sum are truncated to ELEM_W bits.
  - 8'hFF STOP.
- The src2 read is always performed for opcodes 01–05; B is ignored by SCALE and TRANSPOSE.
- PC wraps 15 -> 0.
- dest equal to src1 or src2 is legal; operands are already captured before WRITE.
- nReset assertion in any state immediately clears all state and outputs, including Halted. No pending write completes.
- Enable is never high in FETCH, DECODE, EXEC or HALT.
- InstEnable is high only in FETCH.

Decomposition:
- Shared package matrix_pkg:
  - Parameters ELEM_W, DIM, AW.
  - Opcode constants OP_NOP, OP_ADD, OP_SUB, OP_SCALE, OP_TRANSPOSE, OP_MATMUL, OP_STOP.
  - State enum.
  - Element get/put index functions.
- One natural sub-module: matrix_alu. It is purely combinational, with inputs op, A, B, imm8 and output R. The sequencer and instruction latch stay in the top.

Test Plan:
1. Reset then release with InstAddress 0 holding 32'h01_02_00_01, RAM[0] all elements 3, RAM[1] all elements 5:
   - Required: writes at cycle 6 after release to Address 2 with all elements 8.
   - Status pulses once; PC becomes 1.
2. SUB with A elements 1, B elements 2 -> all elements 16'hFFFF (wrap).
3. SCALE with imm 8'h02, A(0,0) = 16'h8001 -> R(0,0) = 16'h0002 (truncation).
4. TRANSPOSE of A(r,c) = 4r+c -> R(r,c) = 4c+r.
5. MATMUL of A = identity and B(r,c) = 4r+c -> R = B. Then MATMUL with A, B all 2s -> all elements 16.
6. Program {NOP, 8'h77 unknown, STOP}:
   - Required: no RAM strobes; Halted = 1 after 6 cycles and held.
   - Required: asserting nReset mid-HALT clears Halted, and fetch resumes at address 0.
